// File: rtl/bpu_pkg.sv
// Shared types and constants for the branch prediction unit.
// Holds the 2-bit counter encodings, default table depths and the BTB entry layout.
// The tag field is sized for the smallest legal BTB so every depth fits.
package bpu_pkg;

    // Direction counter states
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam int BHT_DEPTH_DEF = 64;
    localparam int BTB_DEPTH_DEF = 16;

    // Upper pc bits above the word offset; smaller tags are zero-extended
    localparam int TAG_W = 30;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic             is_jalr;
    } btb_entry_t;

    // Saturating step of a 2-bit direction counter
    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        if (taken)
            return (c == ST) ? ST : c + 2'd1;
        else
            return (c == SNT) ? SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer: one combinational read port, one write port.
// Latency: read is combinational, write lands on the next rising clk edge.
// Backpressure: none; a write always overwrites the addressed entry.
// BPU_STATS_EN adds a view of the entry currently at the write index.
module bpu_btb import bpu_pkg::*; #(
    parameter int DEPTH = BTB_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output btb_entry_t               rd_entry,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  btb_entry_t               wr_entry
`ifdef BPU_STATS_EN
    ,
    output btb_entry_t               wr_old
`endif
);

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [31:0]      target_q [DEPTH];
    logic             jalr_q   [DEPTH];

    // Valid bits are the only state that needs clearing on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valid_q <= '0;
        else if (wr_en)
            valid_q[wr_idx] <= wr_entry.valid;
    end

    // Payload storage, meaningless until the matching valid bit is set
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]    <= wr_entry.tag;
            target_q[wr_idx] <= wr_entry.target;
            jalr_q[wr_idx]   <= wr_entry.is_jalr;
        end
    end

    // Read sees pre-write contents, giving read-before-write on same-index collisions
    always_comb begin
        rd_entry         = '0;
        rd_entry.valid   = valid_q[rd_idx];
        rd_entry.tag     = tag_q[rd_idx];
        rd_entry.target  = target_q[rd_idx];
        rd_entry.is_jalr = jalr_q[rd_idx];
    end

`ifdef BPU_STATS_EN
    // Current contents at the write index, used to score the resolved branch
    always_comb begin
        wr_old         = '0;
        wr_old.valid   = valid_q[wr_idx];
        wr_old.tag     = tag_q[wr_idx];
        wr_old.target  = target_q[wr_idx];
        wr_old.is_jalr = jalr_q[wr_idx];
    end
`endif

endmodule

// File: rtl/bpu.sv
// Branch predictor: 2-bit BHT for direction plus a direct-mapped BTB for targets.
// Latency: prediction registered 1 cycle after fetch_valid; updates land next edge.
// Backpressure: none; flush drops the in-flight prediction. BPU_STATS_EN adds stats counters.
module bpu import bpu_pkg::*; #(
    parameter int BHT_DEPTH = BHT_DEPTH_DEF,
    parameter int BTB_DEPTH = BTB_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    input  logic        flush,
    output logic        pred_valid,
    output logic        pred_direction,
    output logic [31:0] pred_addr,
    output logic        pred_hit,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_b_type,
    input  logic        upd_real_direction,
    input  logic [31:0] upd_addr
`ifdef BPU_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
`endif
);

    localparam int HW = $clog2(BHT_DEPTH);
    localparam int BW = $clog2(BTB_DEPTH);

    logic [1:0] bht [BHT_DEPTH];

    logic [HW-1:0]    f_hidx, u_hidx;
    logic [BW-1:0]    f_bidx, u_bidx;
    logic [TAG_W-1:0] f_tag, u_tag;
    btb_entry_t       f_entry, wr_entry;
    logic             wr_en;
    logic             nxt_hit, nxt_dir;
    logic [31:0]      nxt_addr, f_seq;

    assign f_hidx = fetch_pc[HW+1:2];
    assign u_hidx = upd_pc[HW+1:2];
    assign f_bidx = fetch_pc[BW+1:2];
    assign u_bidx = upd_pc[BW+1:2];
    assign f_tag  = TAG_W'(fetch_pc >> (BW + 2));
    assign u_tag  = TAG_W'(upd_pc >> (BW + 2));
    assign f_seq  = fetch_pc + 32'd4;

    // Jalr always writes; conditional branches only write when taken
    assign wr_en = upd_valid & (~upd_b_type | upd_real_direction);

    always_comb begin
        wr_entry         = '0;
        wr_entry.valid   = 1'b1;
        wr_entry.tag     = u_tag;
        wr_entry.target  = upd_addr;
        wr_entry.is_jalr = ~upd_b_type;
    end

`ifdef BPU_STATS_EN
    btb_entry_t u_old;
`endif

    bpu_btb #(.DEPTH(BTB_DEPTH)) u_btb (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (f_bidx),
        .rd_entry (f_entry),
        .wr_en    (wr_en),
        .wr_idx   (u_bidx),
        .wr_entry (wr_entry)
`ifdef BPU_STATS_EN
        ,
        .wr_old   (u_old)
`endif
    );

    // Combine BTB hit, entry kind and counter into the next prediction
    always_comb begin
        nxt_hit  = f_entry.valid && (f_entry.tag == f_tag);
        nxt_dir  = 1'b0;
        nxt_addr = f_seq;
        if (nxt_hit) begin
            nxt_dir  = f_entry.is_jalr | bht[f_hidx][1];
            nxt_addr = nxt_dir ? f_entry.target : f_seq;
        end
    end

    // Register the prediction; flush only kills the valid, the data is don't-care
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid     <= 1'b0;
            pred_direction <= 1'b0;
            pred_addr      <= '0;
            pred_hit       <= 1'b0;
        end else begin
            pred_valid <= fetch_valid & ~flush;
            if (fetch_valid) begin
                pred_direction <= nxt_dir;
                pred_addr      <= nxt_addr;
                pred_hit       <= nxt_hit;
            end
        end
    end

    // Train the direction counters on resolved conditional branches only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++)
                bht[i] <= WNT;
        end else if (upd_valid && upd_b_type) begin
            bht[u_hidx] <= ctr_next(bht[u_hidx], upd_real_direction);
        end
    end

`ifdef BPU_STATS_EN
    logic        p_hit, p_dir, a_dir, mispred;
    logic [31:0] p_tgt, a_tgt, u_seq;

    // Re-derive what the tables currently predict for the resolved pc
    always_comb begin
        u_seq   = upd_pc + 32'd4;
        p_hit   = u_old.valid && (u_old.tag == u_tag);
        p_dir   = p_hit & (u_old.is_jalr | bht[u_hidx][1]);
        p_tgt   = p_dir ? u_old.target : u_seq;
        a_dir   = ~upd_b_type | upd_real_direction;
        a_tgt   = a_dir ? upd_addr : u_seq;
        mispred = (p_dir != a_dir) || (p_tgt != a_tgt);
    end

    // Free-running wrap-around statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else if (upd_valid) begin
            stat_branches <= stat_branches + 32'd1;
            if (mispred)
                stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bpu.sv
// Directed scoreboard bench for bpu: stimulus pushes expected predictions,
// a negedge monitor pops and compares whenever pred_valid is seen.
module tb_bpu;
    import bpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid, flush, upd_valid, upd_b_type, upd_real_direction;
    logic [31:0] fetch_pc, upd_pc, upd_addr;
    logic        pred_valid, pred_direction, pred_hit;
    logic [31:0] pred_addr;

    always #5 clk = ~clk;

    bpu dut (
        .clk                (clk),
        .rst                (rst),
        .fetch_valid        (fetch_valid),
        .fetch_pc           (fetch_pc),
        .flush              (flush),
        .pred_valid         (pred_valid),
        .pred_direction     (pred_direction),
        .pred_addr          (pred_addr),
        .pred_hit           (pred_hit),
        .upd_valid          (upd_valid),
        .upd_pc             (upd_pc),
        .upd_b_type         (upd_b_type),
        .upd_real_direction (upd_real_direction),
        .upd_addr           (upd_addr)
    );

    typedef struct {
        logic        hit;
        logic        dir;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge
    task automatic step(input logic fv, input logic [31:0] pc, input logic fl,
                        input logic uv, input logic [31:0] upc, input logic bt,
                        input logic rd, input logic [31:0] ua);
        @(posedge clk);
        #1;
        fetch_valid        = fv;
        fetch_pc           = pc;
        flush              = fl;
        upd_valid          = uv;
        upd_pc             = upc;
        upd_b_type         = bt;
        upd_real_direction = rd;
        upd_addr           = ua;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] pc, input logic hit, input logic dir, input logic [31:0] addr);
        exp_t e;
        step(1'b1, pc, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        e.hit = hit; e.dir = dir; e.addr = addr;
        exp_q.push_back(e);
    endtask

    task automatic update(input logic [31:0] upc, input logic bt, input logic rd, input logic [31:0] ua);
        step(1'b0, 32'h0, 1'b0, 1'b1, upc, bt, rd, ua);
    endtask

    // Monitor: every valid prediction must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && pred_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pred: pred_valid=1 addr=0x%08h with nothing expected", pred_addr);
            end else begin
                e = exp_q.pop_front();
                chk("pred_hit", pred_hit, e.hit);
                chk("pred_direction", pred_direction, e.dir);
                chk("pred_addr", pred_addr, e.addr);
            end
        end
    end

    initial begin
        exp_t e;
        rst = 1'b1;
        fetch_valid = 0; fetch_pc = 0; flush = 0; upd_valid = 0;
        upd_pc = 0; upd_b_type = 0; upd_real_direction = 0; upd_addr = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_pred_valid", pred_valid, 0);
        chk("rst_pred_direction", pred_direction, 0);
        chk("rst_pred_hit", pred_hit, 0);
        chk("rst_pred_addr", pred_addr, 0);
        chk("rst_bht0", dut.bht[0], WNT);
        chk("rst_bht63", dut.bht[63], WNT);

        // Cold miss
        fetch(32'h100, 0, 0, 32'h104);
        // Same-cycle fetch and taken update: read-before-write gives a miss
        step(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h80);
        e.hit = 0; e.dir = 0; e.addr = 32'h104; exp_q.push_back(e);
        // Second taken update with a fetch: hit, counter still WT before this edge
        step(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h80);
        e.hit = 1; e.dir = 1; e.addr = 32'h80; exp_q.push_back(e);
        fetch(32'h100, 1, 1, 32'h80);
        @(negedge clk);
        chk("bht_st", dut.bht[0], ST);

        // Three not-taken updates from ST reach SNT
        repeat (3) update(32'h100, 1'b1, 1'b0, 32'h80);
        idle();
        @(negedge clk);
        chk("bht_snt", dut.bht[0], SNT);
        fetch(32'h100, 1, 0, 32'h104);
        // One more not-taken saturates
        update(32'h100, 1'b1, 1'b0, 32'h80);
        fetch(32'h100, 1, 0, 32'h104);
        @(negedge clk);
        chk("bht_sat_snt", dut.bht[0], SNT);

        // jalr at 0x200 shares BHT and BTB index 0 with 0x100; counter is SNT
        update(32'h200, 1'b0, 1'b1, 32'h3000);
        fetch(32'h200, 1, 1, 32'h3000);
        fetch(32'h100, 0, 0, 32'h104);
        @(negedge clk);
        chk("bht_jalr_untouched", dut.bht[0], SNT);

        // Fall-through wraps at the top of the address space
        fetch(32'hFFFF_FFFC, 0, 0, 32'h0000_0000);

        // Flush kills the prediction but the coincident update still trains
        step(1'b1, 32'h200, 1'b1, 1'b1, 32'h300, 1'b1, 1'b1, 32'h500);
        idle();
        @(negedge clk);
        chk("flush_pred_valid", pred_valid, 0);
        chk("flush_upd_bht", dut.bht[0], WNT);
        fetch(32'h300, 1, 0, 32'h304);
        fetch(32'h200, 0, 0, 32'h204);
        idle();
        @(negedge clk);

        // Reset mid-stream with a fetch and a taken update in flight
        step(1'b1, 32'h300, 1'b0, 1'b1, 32'h304, 1'b1, 1'b1, 32'h900);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("midrst_pred_valid", pred_valid, 0);
        chk("midrst_pred_direction", pred_direction, 0);
        chk("midrst_pred_hit", pred_hit, 0);
        chk("midrst_pred_addr", pred_addr, 0);
        fetch_valid = 0; upd_valid = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        fetch(32'h300, 0, 0, 32'h304);
        fetch(32'h304, 0, 0, 32'h308);
        idle();
        @(negedge clk);
        chk("midrst_bht1", dut.bht[1], WNT);
        chk("midrst_bht0", dut.bht[0], WNT);

        repeat (2) idle();
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bpu.md
BPU -- requirements
Module: bpu

Interface
REQ-001 Parameter BHT_DEPTH, default 64, number of 2-bit direction counters, power of two.
REQ-002 Parameter BTB_DEPTH, default 16, number of direct-mapped target entries, power of two.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 fetch_valid  input  1  lookup request this cycle.
REQ-006 fetch_pc  input  32  address of the fetched instruction.
REQ-007 flush  input  1  discard any prediction in flight.
REQ-008 pred_valid  output  1  prediction outputs valid.
REQ-009 pred_direction  output  1  1 = predicted taken; feeds the resolver's pre_direction.
REQ-010 pred_addr  output  32  predicted next address; feeds the resolver's pre_addr.
REQ-011 pred_hit  output  1  BTB tag matched.
REQ-012 upd_valid  input  1  resolved branch from the branch resolution unit.
REQ-013 upd_pc  input  32  address of the resolved branch.
REQ-014 upd_b_type  input  1  1 = conditional B-type; 0 = jalr.
REQ-015 upd_real_direction  input  1  resolved direction.
REQ-016 upd_addr  input  32  resolved target address.

Function
REQ-017 Lookup latency SHALL be exactly 1 cycle: pred_valid = fetch_valid & ~flush, registered.
REQ-018 BHT index SHALL be pc[log2(BHT_DEPTH)+1:2].
REQ-019 BTB index SHALL be pc[log2(BTB_DEPTH)+1:2].
REQ-020 BTB tag SHALL be the remaining upper pc bits.
REQ-021 Each BTB entry SHALL hold valid, tag, target[31:0] and is_jalr.
REQ-022 On a BTB hit with is_jalr=1: pred_direction=1, pred_addr=target.
REQ-023 On a BTB hit with is_jalr=0: pred_direction=counter[1]; pred_addr=target if taken, else fetch_pc+4.
REQ-024 On a BTB miss: pred_direction=0, pred_addr=fetch_pc+4 (wraps mod 2^32), pred_hit=0.
REQ-025 Counter FSM states: SNT=00, WNT=01, WT=10, ST=11.
REQ-026 When upd_valid & upd_b_type: taken increments the counter, not-taken decrements it; the counter saturates at ST and SNT.
REQ-027 BTB write on upd_valid when (upd_b_type & upd_real_direction) or ~upd_b_type: valid=1, tag and target=upd_addr, is_jalr=~upd_b_type; the write overwrites any existing entry.
REQ-028 A not-taken B-type update SHALL NOT modify the BTB.
REQ-029 A simultaneous lookup and update to the same index SHALL use read-before-write: the prediction reflects the pre-update state.
REQ-030 flush in the same cycle as fetch_valid SHALL force pred_valid=0 next cycle; updates are unaffected by flush.

Reset
REQ-031 On rst, all counters SHALL be set to WNT and all BTB valid bits cleared.
REQ-032 On rst, pred_valid, pred_direction and pred_hit SHALL be 0 and pred_addr SHALL be 0.
REQ-033 rst asserted mid-operation SHALL discard an in-flight prediction and a coincident update.

Configuration
REQ-034 With BPU_STATS_EN defined, stat_branches[31:0] SHALL count upd_valid, and stat_mispred[31:0] SHALL count updates whose resolved direction or target differs from the stored prediction; both counters wrap, are reset to 0, and are outputs.
REQ-035 Without BPU_STATS_EN, neither the stats ports nor the stats logic SHALL exist.

Structure
REQ-036 Package bpu_pkg SHALL hold the counter state encodings, the default depths and the BTB entry struct typedef.
REQ-037 Sub-module bpu_btb (tag/target storage with one read and one write port) SHALL be instantiated once.

Verification
REQ-038 Reset, then fetch pc=0x100 -> one cycle later pred_valid=1, pred_hit=0, pred_direction=0, pred_addr=0x104.
REQ-039 Two taken B-type updates at pc=0x100 with target 0x80, then fetch 0x100 -> direction=1, addr=0x80; counter=ST.
REQ-040 From ST, three not-taken updates, then one more -> counter SNT, holds at SNT, prediction not-taken with addr 0x104.
REQ-041 jalr update pc=0x200 with target 0x3000, then fetch 0x200 -> direction=1, addr=0x3000, regardless of counter state.
REQ-042 Same-cycle fetch and taken update at 0x100 with an empty BTB -> prediction miss; the next fetch hits.
REQ-043 fetch_pc=0xFFFFFFFC with a miss -> pred_addr=0x00000000; flush with fetch -> pred_valid=0; rst mid-stream -> all outputs 0.
